// File: rtl/wb_ram_slave.sv
// wb_ram_slave
// On-chip single-port RAM presented as a Wishbone classic-cycle slave.
// Each request is latched, held for WAIT_STATES extra cycles, executed, and
// answered with a single-cycle ack (legal access) or err (illegal access).
//
// Parameters
//   ADDR_WIDTH   word-address bits; capacity is 2^ADDR_WIDTH 32-bit words
//   WAIT_STATES  extra cycles before ack/err, 0..7
//
// Ports
//   wb_clk_i    clock, rising edge
//   wb_rst_n_i  asynchronous active-low reset
//   wb_cyc_i    bus cycle valid
//   wb_stb_i    strobe; request = cyc & stb
//   wb_we_i     1 = write, 0 = read
//   wb_adr_i    byte address ([31:28] slot select, [1:0] ignored)
//   wb_sel_i    byte-lane enables
//   wb_dat_i    write data
//   wb_dat_o    read data, non-zero only while wb_ack_o is high
//   wb_ack_o    normal termination pulse
//   wb_err_o    error termination pulse
module wb_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [27:2] adr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    logic                  req;
    logic                  legal;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] word_idx;

    // Slot-select and byte-offset address bits carry no meaning here.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:28], wb_adr_i[1:0]};

    assign req      = wb_cyc_i && wb_stb_i;
    assign word_idx = adr_q[ADDR_WIDTH+1:2];

    // The word index never carries into the upper bits, so any set bit above
    // the RAM window, or an empty byte-lane mask, makes the access illegal.
    assign legal    = (adr_q[27:ADDR_WIDTH+2] == '0) && (sel_q != 4'b0000);

    // The write fires on the WAIT->RESP edge only; an abort in the same cycle
    // (req low) suppresses it.
    assign do_write = (state == ST_WAIT) && req && (cnt == 3'd0) && legal && we_q;

    // Main controller: latch the request, count wait states, then respond for
    // exactly one cycle. All outputs are registered here.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'b0000;
            dat_q    <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        adr_q <= wb_adr_i[27:2];
                        we_q  <= wb_we_i;
                        sel_q <= wb_sel_i;
                        dat_q <= wb_dat_i;
                        cnt   <= 3'(WAIT_STATES);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= ST_RESP;
                        if (!legal) begin
                            wb_err_o <= 1'b1;
                        end else begin
                            wb_ack_o <= 1'b1;
                            if (!we_q) begin
                                wb_dat_o <= mem[word_idx];
                            end
                        end
                    end
                end
                ST_RESP: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    wb_dat_o <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM array with byte-lane writes; deliberately not reset so contents
    // survive a reset pulse.
    always_ff @(posedge wb_clk_i) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[word_idx][8*i +: 8] <= dat_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave
// Drives three wb_ram_slave instances (WAIT_STATES = 1, 0, 7) with directed
// and random Wishbone transfers and compares every response against a
// word-array memory model and the latency/termination rules of the slave.
module tb_wb_ram_slave;

    localparam int NINST = 3;

    logic clk;
    logic rst_n;

    logic [NINST-1:0]       cyc, stb, we, ack, err;
    logic [NINST-1:0][31:0] adr, dat_w, dat_r;
    logic [NINST-1:0][3:0]  sel;

    int checks = 0;
    int errors = 0;

    // Reference memory: one 1024-word array per instance.
    logic [31:0] mdl [NINST][1024];

    localparam logic [31:0] ADDR_LIST [8] = '{32'h0, 32'h4, 32'h10, 32'h20,
                                              32'h40, 32'h100, 32'h800, 32'hFFC};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        wb_ram_slave #(
            .ADDR_WIDTH (10),
            .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 7)
        ) u_dut (
            .wb_clk_i  (clk),
            .wb_rst_n_i(rst_n),
            .wb_cyc_i  (cyc[g]),
            .wb_stb_i  (stb[g]),
            .wb_we_i   (we[g]),
            .wb_adr_i  (adr[g]),
            .wb_sel_i  (sel[g]),
            .wb_dat_i  (dat_w[g]),
            .wb_dat_o  (dat_r[g]),
            .wb_ack_o  (ack[g]),
            .wb_err_o  (err[g])
        );
    end

    function automatic int wsOf(input int g);
        return (g == 0) ? 1 : (g == 1) ? 0 : 7;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Issues one request (called #1 after a rising edge), waits for the
    // termination and checks it is a single-cycle pulse. Leaves cyc/stb high
    // so the caller may chain a back-to-back request.
    task automatic applyStimulus(input int g, input logic w, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d,
                                 output logic got_ack, output logic got_err,
                                 output logic [31:0] got_dat, output int lat,
                                 output time t_ack);
        cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w;
        adr[g] = a; sel[g] = s; dat_w[g] = d;
        @(posedge clk); #1;
        lat = -1; got_ack = 1'b0; got_err = 1'b0; got_dat = '0; t_ack = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack[g] || err[g]) begin
                lat = i; got_ack = ack[g]; got_err = err[g];
                got_dat = dat_r[g]; t_ack = $time;
                break;
            end
        end
        @(posedge clk); #1;
        checkOutput($sformatf("pulse_fall_i%0d", g), 32'({ack[g], err[g]}), 32'd0);
        checkOutput($sformatf("dat_clear_i%0d", g), dat_r[g], 32'd0);
    endtask

    task automatic busIdle(input int g);
        cyc[g] = 1'b0; stb[g] = 1'b0;
        @(posedge clk); #1;
    endtask

    // One transfer checked against the model: legality, latency, data.
    task automatic doXfer(input int g, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input bit idle_after, output logic [31:0] rd, output time t_ack);
        logic        ok;
        logic [31:0] exp_dat;
        logic        ga, ge;
        int          lat;
        int          idx;
        idx = int'(a[11:2]);
        ok  = (a[27:12] == 16'h0) && (s != 4'b0000);
        exp_dat = (ok && !w) ? mdl[g][idx] : 32'h0;
        applyStimulus(g, w, a, s, d, ga, ge, rd, lat, t_ack);
        checkOutput($sformatf("ack_i%0d_a%08h", g, a), 32'(ga), 32'(ok));
        checkOutput($sformatf("err_i%0d_a%08h", g, a), 32'(ge), 32'(!ok));
        checkOutput($sformatf("lat_i%0d_a%08h", g, a), 32'(lat), 32'(1 + wsOf(g)));
        checkOutput($sformatf("rdat_i%0d_a%08h", g, a), rd, exp_dat);
        if (ok && w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[g][idx][8*b +: 8] = d[8*b +: 8];
        end
        if (idle_after) busIdle(g);
    endtask

    initial begin
        logic [31:0] rd;
        time         t0, t1;
        logic [31:0] a;
        logic [3:0]  s;

        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; adr = '0; sel = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NINST; g++) begin
            checkOutput($sformatf("rst_ack_i%0d", g), 32'(ack[g]), 32'd0);
            checkOutput($sformatf("rst_err_i%0d", g), 32'(err[g]), 32'd0);
            checkOutput($sformatf("rst_dat_i%0d", g), dat_r[g], 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every tracked word a known value in every instance.
        for (int g = 0; g < NINST; g++)
            for (int k = 0; k < 8; k++)
                doXfer(g, 1'b1, ADDR_LIST[k], 4'hF, $urandom, 1'b1, rd, t0);

        // Full-word write then read.
        doXfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, rd, t0);
        doXfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, rd, t0);
        checkOutput("full_rw", rd, 32'hDEADBEEF);

        // Byte-lane merge.
        doXfer(0, 1'b1, 32'h10, 4'hF, 32'h11223344, 1'b1, rd, t0);
        doXfer(0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, 1'b1, rd, t0);
        doXfer(0, 1'b0, 32'h10, 4'h3, 32'h0, 1'b1, rd, t0);
        checkOutput("byte_lanes", rd, 32'h11BB33DD);

        // Error terminations leave memory untouched.
        doXfer(0, 1'b1, 32'h4, 4'hF, 32'hCAFEF00D, 1'b1, rd, t0);
        doXfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, rd, t0);
        doXfer(0, 1'b1, 32'h4, 4'h0, 32'h0BADBAD0, 1'b1, rd, t0);
        doXfer(0, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, rd, t0);
        checkOutput("err_keeps_word", rd, 32'hCAFEF00D);

        // Abort during WAIT: no termination, no write.
        doXfer(0, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b1, rd, t0);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
        adr[0] = 32'h20; sel[0] = 4'hF; dat_w[0] = 32'h55555555;
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_term", 32'({ack[0], err[0]}), 32'd0);
        end
        doXfer(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, rd, t0);
        checkOutput("abort_no_write", rd, 32'h12345678);

        // Back-to-back reads at the wait-state extremes.
        for (int g = 1; g < NINST; g++) begin
            doXfer(g, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, rd, t0);
            doXfer(g, 1'b0, 32'hFFC, 4'hF, 32'h0, 1'b1, rd, t1);
            checkOutput($sformatf("b2b_period_i%0d", g), 32'((t1 - t0) / 10),
                        32'(wsOf(g) + 3));
        end

        // Reset in the middle of a WAIT_STATES=7 write.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'h40; sel[2] = 4'hF; dat_w[2] = 32'h99999999;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ack", 32'(ack[2]), 32'd0);
        checkOutput("midrst_err", 32'(err[2]), 32'd0);
        checkOutput("midrst_dat", dat_r[2], 32'd0);
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        doXfer(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, rd, t0);

        // Random traffic over the tracked words.
        for (int g = 0; g < NINST; g++) begin
            for (int n = 0; n < 40; n++) begin
                a = ADDR_LIST[$urandom_range(0, 7)];
                a[31:28] = 4'($urandom);
                a[1:0]   = 2'($urandom);
                if ($urandom_range(0, 7) == 0) a[$urandom_range(12, 27)] = 1'b1;
                s = 4'($urandom);
                doXfer(g, 1'($urandom), a, s, $urandom, 1'b1, rd, t0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

On-chip single-port RAM exposed as a Wishbone classic-cycle slave, the responder end of the CPU's instruction/data Wishbone master ports. It attaches to a free slave slot of the Wishbone interconnect to provide zero-boot scratch/stack memory. It provides programmable wait states, byte-lane writes and an error response for illegal accesses.

## Interface
- ADDR_WIDTH, 10: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words (4 KB default).
- WAIT_STATES, 1: extra cycles inserted before ack/err, legal range 0..7.
- wb_clk_i  in  1  single clock; all logic rising-edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; a request exists when wb_cyc_i and wb_stb_i are both 1.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address; [ADDR_WIDTH+1:2] selects the word, [27:ADDR_WIDTH+2] must be 0, [31:28] ignored (interconnect slot select), [1:0] ignored.
- wb_sel_i  in  4  byte lanes; bit n enables bits 8n+7:8n.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack_o=1, 0 otherwise.
- wb_ack_o  out  1  normal termination, one-cycle pulse.
- wb_err_o  out  1  error termination, one-cycle pulse.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on a request, latch adr/we/sel/dat, load the wait counter with WAIT_STATES, and go to WAIT. Otherwise stay in IDLE.
- WAIT, counter ≠ 0: decrement.
- WAIT, counter = 0: execute the access and go to RESP.
- RESP: exactly one cycle with ack or err high, then return to IDLE unconditionally.
- Request illegal (latched adr[27:ADDR_WIDTH+2] ≠ 0 or latched sel = 4'b0000):
  - no memory access
  - wb_err_o=1 in RESP, wb_ack_o=0, wb_dat_o=0.
- Legal write:
  - RAM word written at the WAIT→RESP edge, only lanes with sel=1.
  - Other lanes are unchanged.
  - wb_dat_o=0.
- Legal read:
  - RAM word registered into wb_dat_o at the WAIT→RESP edge, all 32 bits regardless of sel.
  - Cleared to 0 at the RESP→IDLE edge.
- Abort: wb_cyc_i or wb_stb_i low while in WAIT → go to IDLE at the next edge, no write, no ack/err.
- The inputs are never re-sampled during WAIT/RESP. Only the latched values are used.
- wb_ack_o and wb_err_o are never both 1.
- RAM contents are not reset; they persist across reset.

## Timing
- Reset (wb_rst_n_i=0, asynchronous): state=IDLE, counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
- Reset mid-access: an in-flight write is discarded, and no ack/err is produced.
- Latency: request sampled at edge N; ack/err rises at edge N+1+WAIT_STATES and falls at edge N+2+WAIT_STATES.
- Default WAIT_STATES=1: ack is high in the 3rd cycle after the request is first seen.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The master drops stb at the edge it samples ack. The next request is sampled no earlier than the edge after ack falls, giving a minimum 1 idle cycle between terminations.
- Back-to-back throughput: one transfer per WAIT_STATES+3 cycles.
- Write-then-read of the same address in consecutive transfers returns the new data.
- Address wrap: the word index takes no carry into [27:ADDR_WIDTH+2]. The top word 0x...FFC is legal, and 0x1000 (with ADDR_WIDTH=10) is illegal.

## Test plan
- Reset value: hold wb_rst_n_i=0 mid-WAIT, then release → wb_ack_o=0, wb_err_o=0, wb_dat_o=0, and the next access completes normally.
- Full write/read: write 0xDEADBEEF to 0x00000010 with sel=4'hF, then read 0x00000010 → read returns 0xDEADBEEF. Ack is high exactly at edge N+2 for WAIT_STATES=1.
- Byte lanes: write 0x11223344 sel=F, then write 0xAABBCCDD sel=4'b0101 to the same address, then read → 0x11BB33DD.
- Error: read 0x00001000, then write sel=0 to 0x00000004 →
  - wb_err_o one-cycle pulse each time, no ack
  - wb_dat_o=0
  - word 0x4 unchanged.
- Abort: start a write of 0x55555555 to 0x20, drop wb_cyc_i in WAIT → no ack/err. A subsequent read of 0x20 returns the prior value.
- Wait-state sweep: WAIT_STATES=0 and 7; back-to-back reads of 0x0 and 0xFFC →
  - ack at N+1 and N+8 respectively
  - one idle cycle minimum between acks
  - correct data.
